edp_muldiv_seq: RTL and testbench

//  Parametrised iterative multiply/divide sequencer for the EBOX datapath.
//  It runs a full signed MUL or DIV on its own: one start pulse in, one done pulse out.
//  The microcode no longer has to step MQ shifts and AD adds itself.

---
 rtl/edp_muldiv_seq.sv | 157 +++++++++++++++
 tb/tb_edp_muldiv_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/edp_muldiv_seq.sv
// Iterative signed multiply/divide sequencer for the EBOX datapath.
// One start pulse runs a full 2W-bit MUL or 2W/W DIV and ends with a single done pulse.
module edp_muldiv_seq #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             op,
    input  logic [WIDTH-1:0] a_hi,
    input  logic [WIDTH-1:0] a_lo,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             ovf
);
    localparam int W     = WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ITER   = 3'd2;
    localparam logic [2:0] S_FIX    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    function automatic logic [W-1:0] cond_neg(input logic neg, input logic [W-1:0] v);
        return neg ? -v : v;
    endfunction

    // Unsigned shift-add: {hi,lo} shifts right one place, multiplier bits leave from lo[0].
    function automatic logic [2*W+1:0] mul_step(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                                input logic [W-1:0] m);
        logic [W:0] sum;
        sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        return {2'b00, sum[W:1], sum[0], lo[W-1:1]};
    endfunction

    // Non-restoring step: partial remainder r stays in [-m, m), quotient bits enter q from the right.
    function automatic logic [2*W+1:0] div_step(input logic [W+1:0] r, input logic [W-1:0] q,
                                                input logic [W-1:0] m);
        logic signed [W+1:0] r2;
        logic signed [W+1:0] dv;
        logic signed [W+1:0] rn;
        r2 = $signed({r[W:0], q[W-1]});
        dv = $signed({2'b00, m});
        rn = r[W+1] ? r2 + dv : r2 - dv;
        return {rn, q[W-2:0], ~rn[W+1]};
    endfunction

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             op_r, sign_q, sign_r, ovf_r;
    logic [W-1:0]     a_hi_r, a_lo_r, b_r, m_r, lo_r;
    logic [W+1:0]     acc;

    logic             a_neg, b_neg, div_ovf;
    logic [W-1:0]     mag_a, mag_b;
    logic [2*W-1:0]   mag_d;
    logic [W+1:0]     st_r;
    logic [W-1:0]     st_lo, st_m;
    logic [2*W+1:0]   step_out;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     rem_pos, fix_hi, fix_lo;

    assign busy    = (state != S_IDLE);
    assign a_neg   = a_hi_r[W-1];
    assign b_neg   = b_r[W-1];
    assign mag_a   = cond_neg(a_neg, a_hi_r);
    assign mag_b   = cond_neg(b_neg, b_r);
    assign mag_d   = a_neg ? -{a_hi_r, a_lo_r} : {a_hi_r, a_lo_r};
    assign div_ovf = (b_r == '0) || (mag_d[2*W-1:W-1] >= {1'b0, mag_b});

    // SETUP performs the first step directly from the operand magnitudes.
    always_comb begin
        st_r  = acc;
        st_lo = lo_r;
        st_m  = m_r;
        if (state == S_SETUP) begin
            st_r  = op_r ? {2'b00, mag_d[2*W-1:W]} : '0;
            st_lo = op_r ? mag_d[W-1:0] : mag_b;
            st_m  = op_r ? mag_b : mag_a;
        end
    end

    assign step_out = op_r ? div_step(st_r, st_lo, st_m) : mul_step(st_r[W-1:0], st_lo, st_m);

    assign prod_fix = sign_q ? -{acc[W-1:0], lo_r} : {acc[W-1:0], lo_r};
    assign rem_pos  = acc[W+1] ? acc[W-1:0] + m_r : acc[W-1:0];
    assign fix_hi   = op_r ? cond_neg(sign_q, lo_r) : prod_fix[2*W-1:W];
    assign fix_lo   = op_r ? cond_neg(sign_r, rem_pos) : prod_fix[W-1:0];

    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (start) begin
                    op_r   <= op;
                    a_hi_r <= a_hi;
                    a_lo_r <= a_lo;
                    b_r    <= b;
                end
            end
            S_SETUP: begin
                {acc, lo_r} <= step_out;
                m_r         <= st_m;
                sign_q      <= a_neg ^ b_neg;
                sign_r      <= a_neg;
                ovf_r       <= op_r & div_ovf;
            end
            S_ITER: {acc, lo_r} <= step_out;
            S_FIX: begin
                acc  <= {2'b00, fix_hi};
                lo_r <= fix_lo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE:  if (start && !abort) state <= S_SETUP;
                    S_SETUP: begin
                        cnt   <= CNT_W'(1);
                        state <= (op_r && div_ovf) ? S_FINISH : S_ITER;
                    end
                    S_ITER: begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(W - 1)) state <= S_FIX;
                    end
                    S_FIX:   state <= S_FINISH;
                    S_FINISH: begin
                        state  <= S_IDLE;
                        done   <= 1'b1;
                        res_hi <= ovf_r ? a_hi_r : acc[W-1:0];
                        res_lo <= ovf_r ? a_lo_r : lo_r;
                        ovf    <= ovf_r;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_edp_muldiv_seq.sv
// Directed bench for edp_muldiv_seq: WIDTH=36 directed cases plus a WIDTH=8 back-to-back run
// checked against a behavioural integer model.
module tb_edp_muldiv_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start36, abort36, op36, busy36, done36, ovf36;
    logic [35:0] ahi36, alo36, b36, rhi36, rlo36;
    logic        start8, abort8, op8, busy8, done8, ovf8;
    logic [7:0]  ahi8, alo8, b8, rhi8, rlo8;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    typedef struct packed {
        logic       o;
        logic [7:0] ah;
        logic [7:0] al;
        logic [7:0] bb;
    } op8_t;
    op8_t q8[$];
    logic [7:0] cv [10] = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h40, 8'h7F};
    logic [7:0] dh [6]  = '{8'h00, 8'hFF, 8'h01, 8'hFE, 8'h3F, 8'hC0};

    edp_muldiv_seq #(.WIDTH(36)) dut36 (
        .clk(clk), .reset(rst), .start(start36), .abort(abort36), .op(op36),
        .a_hi(ahi36), .a_lo(alo36), .b(b36), .busy(busy36), .done(done36),
        .res_hi(rhi36), .res_lo(rlo36), .ovf(ovf36)
    );

    edp_muldiv_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst), .start(start8), .abort(abort8), .op(op8),
        .a_hi(ahi8), .a_lo(alo8), .b(b8), .busy(busy8), .done(done8),
        .res_hi(rhi8), .res_lo(rlo8), .ovf(ovf8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h (failure %0d)", tag, obs, exp, fails);
        end
    endtask

    task automatic go36(input logic o, input logic [35:0] ah, input logic [35:0] al,
                        input logic [35:0] bb);
        op36 = o; ahi36 = ah; alo36 = al; b36 = bb; start36 = 1'b1;
        @(posedge clk); #1;
        start36 = 1'b0;
    endtask

    task automatic wait36(output int n);
        n = 0;
        while (!done36 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run36(input string tag, input logic o, input logic [35:0] ah,
                         input logic [35:0] al, input logic [35:0] bb, input logic [35:0] eh,
                         input logic [35:0] el, input logic eo, input int elat);
        int n;
        go36(o, ah, al, bb);
        wait36(n);
        chk({tag, "_lat"}, 64'(n), 64'(elat));
        chk({tag, "_hi"}, 64'(rhi36), 64'(eh));
        chk({tag, "_lo"}, 64'(rlo36), 64'(el));
        chk({tag, "_ovf"}, 64'(ovf36), 64'(eo));
    endtask

    task automatic model8(input logic o, input logic [7:0] ah, input logic [7:0] al,
                          input logic [7:0] bb, output logic [7:0] eh, output logic [7:0] el,
                          output logic eo);
        longint p, d, bv, ad, ab, q, r;
        if (!o) begin
            p  = longint'($signed(ah)) * longint'($signed(bb));
            eh = p[15:8]; el = p[7:0]; eo = 1'b0;
        end else begin
            d  = longint'($signed({ah, al}));
            bv = longint'($signed(bb));
            ad = (d < 0) ? -d : d;
            ab = (bv < 0) ? -bv : bv;
            if (bv == 0 || (ad >> 7) >= ab) begin
                eh = ah; el = al; eo = 1'b1;
            end else begin
                q  = d / bv;
                r  = d % bv;
                eh = q[7:0]; el = r[7:0]; eo = 1'b0;
            end
        end
    endtask

    initial begin
        int n;
        logic [7:0] eh, el;
        logic eo;
        rst = 1'b1;
        start36 = 1'b0; abort36 = 1'b0; op36 = 1'b0; ahi36 = '0; alo36 = '0; b36 = '0;
        start8 = 1'b0; abort8 = 1'b0; op8 = 1'b0; ahi8 = '0; alo8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy36), 64'd0);
        chk("rst_done", 64'(done36), 64'd0);
        chk("rst_hi", 64'(rhi36), 64'd0);
        chk("rst_lo", 64'(rlo36), 64'd0);
        chk("rst_ovf", 64'(ovf36), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // MUL 5 * -3, with operand inputs disturbed after the start edge
        go36(1'b0, 36'd5, 36'd0, 36'hFFFFFFFFD);
        chk("t1_busy_run", 64'(busy36), 64'd1);
        ahi36 = 36'h123456789; b36 = 36'd0;
        wait36(n);
        chk("t1_lat", 64'(n), 64'd38);
        chk("t1_busy_done", 64'(busy36), 64'd0);
        chk("t1_hi", 64'(rhi36), 64'hFFFFFFFFF);
        chk("t1_lo", 64'(rlo36), 64'hFFFFFFFF1);
        chk("t1_ovf", 64'(ovf36), 64'd0);

        run36("t2", 1'b0, 36'h800000000, 36'd0, 36'h800000000, 36'h400000000, 36'd0, 1'b0, 38);
        run36("t3a", 1'b1, 36'hFFFFFFFFF, 36'hFFFFFFFF9, 36'd2,
              36'hFFFFFFFFD, 36'hFFFFFFFFF, 1'b0, 38);
        run36("t3b", 1'b1, 36'd0, 36'd100, 36'hFFFFFFFF9, 36'hFFFFFFFF2, 36'd2, 1'b0, 38);

        // abort while ITER count is 10, then restart on the next cycle
        go36(1'b0, 36'd7, 36'd0, 36'd9);
        repeat (10) @(posedge clk);
        #1 abort36 = 1'b1;
        @(posedge clk); #1;
        abort36 = 1'b0;
        chk("t5_busy", 64'(busy36), 64'd0);
        chk("t5_done", 64'(done36), 64'd0);
        chk("t5_hi", 64'(rhi36), 64'hFFFFFFFF2);
        chk("t5_lo", 64'(rlo36), 64'd2);
        chk("t5_ovf", 64'(ovf36), 64'd0);
        run36("t5r", 1'b0, 36'd5, 36'd0, 36'hFFFFFFFFD, 36'hFFFFFFFFF, 36'hFFFFFFFF1, 1'b0, 38);

        run36("t4a", 1'b1, 36'h123, 36'h456, 36'd0, 36'h123, 36'h456, 1'b1, 2);
        run36("t4b", 1'b1, 36'd3, 36'd0, 36'd3, 36'd3, 36'd0, 1'b1, 2);

        // async reset in the middle of ITER, between clock edges
        go36(1'b0, 36'd5, 36'd0, 36'hFFFFFFFFD);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("ar_busy", 64'(busy36), 64'd0);
        chk("ar_done", 64'(done36), 64'd0);
        chk("ar_hi", 64'(rhi36), 64'd0);
        chk("ar_lo", 64'(rlo36), 64'd0);
        chk("ar_ovf", 64'(ovf36), 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // WIDTH=8: corner pairs and random vectors, start held high throughout
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                q8.push_back('{1'b0, cv[i], 8'($urandom), cv[j]});
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 10; j++)
                q8.push_back('{1'b1, dh[i], 8'($urandom), cv[j]});
        for (int i = 0; i < 120; i++)
            q8.push_back('{1'b1, 8'($urandom_range(0, 7) - 4), 8'($urandom), 8'($urandom)});
        for (int i = 0; i < 60; i++)
            q8.push_back('{1'b0, 8'($urandom), 8'($urandom), 8'($urandom)});

        for (int k = 0; k < q8.size(); k++) begin
            op8 = q8[k].o; ahi8 = q8[k].ah; alo8 = q8[k].al; b8 = q8[k].bb;
            start8 = 1'b1;
            model8(q8[k].o, q8[k].ah, q8[k].al, q8[k].bb, eh, el, eo);
            n = 0;
            @(posedge clk); #1;
            n++;
            while (!done8 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk($sformatf("w8_%0d_lat", k), 64'(n), eo ? 64'd3 : 64'd11);
            chk($sformatf("w8_%0d_busy", k), 64'(busy8), 64'd0);
            chk($sformatf("w8_%0d_hi", k), 64'(rhi8), 64'(eh));
            chk($sformatf("w8_%0d_lo", k), 64'(rlo8), 64'(el));
            chk($sformatf("w8_%0d_ovf", k), 64'(ovf8), 64'(eo));
        end
        start8 = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
